// File: rtl/mod_n_timer_ctrl.sv
// mod_n_timer_ctrl
//   Run-time controller around a programmable modulo-N counter. A modulus
//   (as terminal count) and a repeat count are loaded through a valid/ready
//   config port while idle; start/pause/stop then sequence the counter.
//   Emits a one-cycle wrap pulse per completed period and a one-cycle done
//   pulse with the final wrap of a bounded run.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high
//   cfg_valid  config offer
//   cfg_ready  config accepted when cfg_valid && cfg_ready (high only in IDLE)
//   cfg_term   terminal count (period = cfg_term+1 cycles)
//   cfg_reps   periods per run; 0 = free-running until stop
//   start      one-cycle run request, honoured only in IDLE
//   pause      level; freezes the counter while high
//   stop       one-cycle abort back to IDLE, no done
//   count      current count, 0..term
//   wrap       one-cycle pulse, period completed
//   done       one-cycle pulse, final period completed (bounded runs only)
//   busy       high while running or held
//   rep_idx    completed periods in the current run (saturates at all-ones)

module mod_n_timer_ctrl #(
  parameter int LENGTH = 3,
  parameter int REP_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [LENGTH-1:0] cfg_term,
  input  logic [REP_W-1:0]  cfg_reps,
  input  logic              start,
  input  logic              pause,
  input  logic              stop,
  output logic [LENGTH-1:0] count,
  output logic              wrap,
  output logic              done,
  output logic              busy,
  output logic [REP_W-1:0]  rep_idx
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [LENGTH-1:0] TERM_ONES = {LENGTH{1'b1}};
  localparam logic [REP_W-1:0]  REP_ONES  = {REP_W{1'b1}};

  state_t            state_reg, state_next;
  logic [LENGTH-1:0] count_reg, count_next;
  logic              wrap_reg, wrap_next;
  logic              done_reg, done_next;
  logic              busy_reg, busy_next;
  logic [REP_W-1:0]  rep_reg, rep_next;
  logic [LENGTH-1:0] term_reg, term_next;
  logic [REP_W-1:0]  reps_reg, reps_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      count_reg <= '0;
      wrap_reg  <= 1'b0;
      done_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      rep_reg   <= '0;
      term_reg  <= TERM_ONES;
      reps_reg  <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      wrap_reg  <= wrap_next;
      done_reg  <= done_next;
      busy_reg  <= busy_next;
      rep_reg   <= rep_next;
      term_reg  <= term_next;
      reps_reg  <= reps_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    wrap_next  = 1'b0;
    done_next  = 1'b0;
    busy_next  = busy_reg;
    rep_next   = rep_reg;
    term_next  = term_reg;
    reps_next  = reps_reg;

    unique case (state_reg)
      IDLE: begin
        if (cfg_valid) begin
          term_next = cfg_term;
          reps_next = cfg_reps;
        end
        // stop in IDLE is simply ignored, so start needs no stop qualifier
        if (start) begin
          state_next = RUN;
          count_next = '0;
          rep_next   = '0;
          busy_next  = 1'b1;
        end
      end

      RUN, HOLD: begin
        if (stop) begin
          state_next = IDLE;
          count_next = '0;
          busy_next  = 1'b0;
        end else if (pause) begin
          state_next = HOLD;
        end else begin
          // Leaving HOLD advances on the same edge, so a pause of k cycles
          // stretches the period by exactly k cycles.
          state_next = RUN;
          if (count_reg != term_reg) begin
            count_next = count_reg + 1'b1;
          end else begin
            count_next = '0;
            wrap_next  = 1'b1;
            // Bounded runs never reach all-ones before finishing, so the
            // saturation only matters in free-running mode.
            if (rep_reg != REP_ONES) begin
              rep_next = rep_reg + 1'b1;
            end
            if ((reps_reg != '0) && (rep_reg == reps_reg - 1'b1)) begin
              done_next  = 1'b1;
              state_next = IDLE;
              busy_next  = 1'b0;
            end
          end
        end
      end

      default: begin
        state_next = IDLE;
        count_next = '0;
        busy_next  = 1'b0;
      end
    endcase
  end

  assign cfg_ready = (state_reg == IDLE);
  assign count     = count_reg;
  assign wrap      = wrap_reg;
  assign done      = done_reg;
  assign busy      = busy_reg;
  assign rep_idx   = rep_reg;

endmodule
